// File: rtl/out_drain.sv
// Output drain: captures all core lanes into a two-bank shadow store on k_fin,
// then serialises the active channels to the dst buffer with optional ReLU.
module out_drain #(
  parameter int F_NUM  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  localparam int CH_W  = $clog2(F_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      k_fin,
  input  logic [F_NUM*DATA_W-1:0]   sum,
  input  logic [CH_W-1:0]           od,
  input  logic [ADDR_W-1:0]         os,
  input  logic                      relu,
  output logic                      out_busy,
  output logic                      overrun,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_last
);

  // state | meaning
  // IDLE  | store empty, no write request
  // DRAIN | presenting channel ch_q of bank rd_bank_q
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          count_q, count_d;
  logic                wr_bank_q, rd_bank_q;
  logic [ADDR_W-1:0]   pix_q;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                overrun_q, busy_q;

  logic [F_NUM*DATA_W-1:0] bank_q [2];
  logic [ADDR_W-1:0]       tag_q  [2];

  logic              acc, is_last, last_acc, cap;
  logic [ADDR_W-1:0] next_tag;
  logic [DATA_W-1:0] lane;

  assign acc      = (state_q == DRAIN) && wr_ready;
  assign is_last  = (ch_q == od);
  assign last_acc = acc && is_last;
  // A full store still accepts a capture when the drained bank frees this cycle.
  assign cap      = k_fin && ((count_q != 2'd2) || last_acc);

  // The bank following rd_bank may be receiving its tag in this very cycle.
  assign next_tag = (cap && (wr_bank_q != rd_bank_q)) ? pix_q : tag_q[~rd_bank_q];

  always_comb begin
    count_d = count_q;
    if (cap && !last_acc)
      count_d = count_q + 2'd1;
    else if (!cap && last_acc)
      count_d = count_q - 2'd1;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = DRAIN;
          ch_d    = '0;
          addr_d  = pix_q;
        end
      end
      DRAIN: begin
        if (acc) begin
          if (!is_last) begin
            ch_d   = ch_q + 1'b1;
            addr_d = addr_q + os;
          end else begin
            ch_d = '0;
            if (count_d == 2'd0)
              state_d = IDLE;
            else
              addr_d = next_tag;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= 2'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      pix_q     <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!run) begin
      state_q   <= IDLE;
      count_q   <= 2'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      pix_q     <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      busy_q  <= (count_d == 2'd2);
      if (cap) begin
        wr_bank_q <= ~wr_bank_q;
        pix_q     <= pix_q + 1'b1;
      end
      if (last_acc)
        rd_bank_q <= ~rd_bank_q;
      if (k_fin && !cap)
        overrun_q <= 1'b1;
    end
  end

  // Shadow storage carries no reset; its contents are only visible while draining.
  always_ff @(posedge clk) begin
    if (run && cap) begin
      bank_q[wr_bank_q] <= sum;
      tag_q[wr_bank_q]  <= pix_q;
    end
  end

  assign lane     = bank_q[rd_bank_q][int'(ch_q)*DATA_W +: DATA_W];
  assign wr_valid = (state_q == DRAIN);
  assign wr_addr  = addr_q;
  assign wr_data  = (!wr_valid || (relu && lane[DATA_W-1])) ? '0 : lane;
  assign wr_last  = wr_valid && is_last;
  assign out_busy = busy_q;
  assign overrun  = overrun_q;

endmodule
